// File: rtl/store_to_fetch_receiver.sv
// Fetch-side drain of the store->fetch mailbox: buffers one redirect packet, offers it
// to fetch PC logic, and counts unresolved branches so fetch stalls until redirected.
module store_to_fetch_receiver #(
  parameter int ADDR_W          = 32,
  parameter int NUM_LANES       = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int PKT_W           = 16,
  localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 bus_can_receive,
  input  logic [ADDR_W-1:0]    bus_pc,
  input  logic [NUM_LANES-1:0] bus_exec_mask,
  output logic                 bus_recv,
  input  logic                 branch_issued,
  output logic                 redirect_valid,
  input  logic                 redirect_ready,
  output logic [ADDR_W-1:0]    redirect_pc,
  output logic [NUM_LANES-1:0] redirect_mask,
  output logic                 fetch_stall,
  output logic [CNT_W-1:0]     outstanding_cnt,
  output logic [PKT_W-1:0]     pkt_count,
  output logic                 proto_error
);

  // state | meaning
  // IDLE  | buffer empty; take the mailbox as soon as it is full
  // OFFER | buffer holds a packet offered to fetch; mailbox left full as backpressure
  typedef enum logic {IDLE, OFFER} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  state_t state, state_nxt;
  logic   accept;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    bus_recv       = 1'b0;
    redirect_valid = 1'b0;
    case (state)
      IDLE: begin
        bus_recv = bus_can_receive && !reset;
        if (bus_recv) state_nxt = OFFER;
      end
      OFFER: begin
        redirect_valid = 1'b1;
        if (redirect_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept      = redirect_valid && redirect_ready;
  assign fetch_stall = (outstanding_cnt != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      redirect_pc     <= '0;
      redirect_mask   <= '0;
      outstanding_cnt <= '0;
      pkt_count       <= '0;
      proto_error     <= 1'b0;
    end else begin
      if (bus_recv) begin
        redirect_pc   <= bus_pc;
        redirect_mask <= bus_exec_mask;
        pkt_count     <= pkt_count + PKT_W'(1);
      end
      // an issue and a resolution in the same cycle cancel out
      if (branch_issued && !accept) begin
        if (outstanding_cnt == CNT_MAX) proto_error <= 1'b1;
        else                            outstanding_cnt <= outstanding_cnt + CNT_W'(1);
      end else if (accept && !branch_issued && outstanding_cnt != '0) begin
        outstanding_cnt <= outstanding_cnt - CNT_W'(1);
      end
      // a redirect nobody is waiting for is still delivered, but flagged
      if (bus_recv && outstanding_cnt == '0 && !branch_issued) proto_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_store_to_fetch_receiver.sv
// Bench for store_to_fetch_receiver: per-cycle comparison against a packet-level model,
// directed scenarios with literal expectations, and a narrow-counter instance for wrap.
module tb_store_to_fetch_receiver;

  logic        clk = 1'b0;
  logic        reset, bus_can_receive, branch_issued, redirect_ready;
  logic [31:0] bus_pc;
  logic [3:0]  bus_exec_mask;
  logic        bus_recv, redirect_valid, fetch_stall, proto_error;
  logic [31:0] redirect_pc;
  logic [3:0]  redirect_mask;
  logic [2:0]  outstanding_cnt;
  logic [15:0] pkt_count;

  logic        w_reset, w_can, w_branch, w_ready;
  logic [31:0] w_pc;
  logic [3:0]  w_mask;
  logic        w_recv, w_valid, w_stall, w_err;
  logic [31:0] w_rpc;
  logic [3:0]  w_rmask;
  logic [2:0]  w_cnt;
  logic [5:0]  w_pkt;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  bit wrap_done = 1'b0;
  int nrecv = 0;

  always #5 clk = ~clk;

  store_to_fetch_receiver dut (
    .clk(clk), .reset(reset), .bus_can_receive(bus_can_receive), .bus_pc(bus_pc),
    .bus_exec_mask(bus_exec_mask), .bus_recv(bus_recv), .branch_issued(branch_issued),
    .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
    .redirect_pc(redirect_pc), .redirect_mask(redirect_mask), .fetch_stall(fetch_stall),
    .outstanding_cnt(outstanding_cnt), .pkt_count(pkt_count), .proto_error(proto_error)
  );

  store_to_fetch_receiver #(.PKT_W(6)) dut_w (
    .clk(clk), .reset(w_reset), .bus_can_receive(w_can), .bus_pc(w_pc),
    .bus_exec_mask(w_mask), .bus_recv(w_recv), .branch_issued(w_branch),
    .redirect_valid(w_valid), .redirect_ready(w_ready),
    .redirect_pc(w_rpc), .redirect_mask(w_rmask), .fetch_stall(w_stall),
    .outstanding_cnt(w_cnt), .pkt_count(w_pkt), .proto_error(w_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Packet-level model: a one-slot buffer, a branch count and a drained-packet count.
  bit          m_full;
  logic [31:0] m_pc;
  logic [3:0]  m_mask;
  int          m_cnt, m_pkts, m_old;
  bit          m_err, m_take, m_acc;

  always @(posedge clk) begin
    if (reset) begin
      m_full = 0; m_pc = '0; m_mask = '0; m_cnt = 0; m_pkts = 0; m_err = 0;
    end else begin
      m_old  = m_cnt;
      m_take = !m_full && bus_can_receive;
      m_acc  = m_full && redirect_ready;
      if (branch_issued && !m_acc) begin
        if (m_cnt == 4) m_err = 1;
        else            m_cnt = m_cnt + 1;
      end else if (m_acc && !branch_issued && m_cnt > 0) begin
        m_cnt = m_cnt - 1;
      end
      if (m_take) begin
        if (m_old == 0 && !branch_issued) m_err = 1;
        m_pc   = bus_pc;
        m_mask = bus_exec_mask;
        m_pkts = (m_pkts + 1) % 65536;
        m_full = 1;
      end else if (m_acc) begin
        m_full = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_recv",  64'(bus_recv),        64'(!reset && !m_full && bus_can_receive));
      check("m_valid", 64'(redirect_valid),  64'(m_full));
      check("m_pc",    64'(redirect_pc),     64'(m_pc));
      check("m_mask",  64'(redirect_mask),   64'(m_mask));
      check("m_cnt",   64'(outstanding_cnt), 64'(m_cnt));
      check("m_stall", 64'(fetch_stall),     64'(m_cnt != 0));
      check("m_pkts",  64'(pkt_count),       64'(m_pkts));
      check("m_err",   64'(proto_error),     64'(m_err));
    end
  end

  // Wrap instance: mailbox always full, fetch always ready -> one drain every 2 cycles.
  initial begin
    w_reset = 1; w_can = 1; w_ready = 1; w_branch = 0; w_pc = 32'h0000_0100; w_mask = 4'b1001;
    repeat (2) @(posedge clk);
    #1 w_reset = 0;
    for (int i = 0; i < 140; i++) begin
      @(negedge clk);
      check("wrap_cnt",   64'(w_pkt),   64'(nrecv % 64));
      check("wrap_recv",  64'(w_recv),  64'(i % 2 == 0));
      check("wrap_valid", 64'(w_valid), 64'(i % 2 == 1));
      if (nrecv == 64) check("wrap_zero", 64'(w_pkt), 64'h0);
      if (i % 2 == 0) nrecv++;
    end
    check("wrap_pc",    64'(w_rpc),   64'h100);
    check("wrap_mask",  64'(w_rmask), 64'h9);
    check("wrap_cnt0",  64'(w_cnt),   64'h0);
    check("wrap_stall", 64'(w_stall), 64'h0);
    check("wrap_err",   64'(w_err),   64'h1);
    wrap_done = 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  initial begin
    reset = 1; bus_can_receive = 1; bus_pc = 32'hdead_beef; bus_exec_mask = 4'hf;
    branch_issued = 0; redirect_ready = 0;
    step();
    chk_en = 1;
    neg(); check("rst_recv", 64'(bus_recv), 64'h0);
    step();
    reset = 0; bus_can_receive = 0;
    neg();
    check("rst_valid", 64'(redirect_valid), 64'h0);
    check("rst_pc",    64'(redirect_pc),    64'h0);
    check("rst_cnt",   64'(outstanding_cnt), 64'h0);
    check("rst_pkts",  64'(pkt_count),      64'h0);
    check("rst_err",   64'(proto_error),    64'h0);

    // branch at t0, mailbox at t2, accept at t3
    step(); branch_issued = 1;
    step(); branch_issued = 0;
    neg(); check("t1_stall", 64'(fetch_stall), 64'h1); check("t1_cnt", 64'(outstanding_cnt), 64'h1);
    step(); bus_can_receive = 1; bus_pc = 32'h0000_1040; bus_exec_mask = 4'b1011;
    neg(); check("t2_recv", 64'(bus_recv), 64'h1); check("t2_stall", 64'(fetch_stall), 64'h1);
    step(); bus_can_receive = 0; redirect_ready = 1;
    neg();
    check("t3_valid", 64'(redirect_valid), 64'h1);
    check("t3_pc",    64'(redirect_pc),    64'h1040);
    check("t3_mask",  64'(redirect_mask),  64'hb);
    check("t3_stall", 64'(fetch_stall),    64'h1);
    step(); redirect_ready = 0;
    neg();
    check("t4_cnt",   64'(outstanding_cnt), 64'h0);
    check("t4_stall", 64'(fetch_stall),     64'h0);
    check("t4_valid", 64'(redirect_valid),  64'h0);
    check("t4_pkts",  64'(pkt_count),       64'h1);
    check("t4_err",   64'(proto_error),     64'h0);

    // backpressure with a second packet waiting in the mailbox
    step(); branch_issued = 1;
    step();
    step(); branch_issued = 0; bus_can_receive = 1; bus_pc = 32'h0000_2000; bus_exec_mask = 4'b0001;
    step(); bus_pc = 32'h0000_3000; bus_exec_mask = 4'b0110;
    for (int i = 0; i < 5; i++) begin
      neg();
      check("bp_recv", 64'(bus_recv), 64'h0);
      check("bp_pc",   64'(redirect_pc), 64'h2000);
      step();
    end
    redirect_ready = 1;
    neg(); check("bp_valid", 64'(redirect_valid), 64'h1);
    step(); redirect_ready = 0;
    neg(); check("bp_drain", 64'(bus_recv), 64'h1);
    step(); bus_can_receive = 0;
    neg();
    check("bp_pc2",   64'(redirect_pc),   64'h3000);
    check("bp_mask2", 64'(redirect_mask), 64'h6);
    check("bp_pkts",  64'(pkt_count),     64'h3);
    redirect_ready = 1;
    step(); redirect_ready = 0;
    neg(); check("bp_cnt", 64'(outstanding_cnt), 64'h0); check("bp_err", 64'(proto_error), 64'h0);

    // saturation: 5 issues against a limit of 4
    reset = 1;
    step(); reset = 0; branch_issued = 1;
    repeat (5) step();
    branch_issued = 0;
    neg(); check("sat_cnt", 64'(outstanding_cnt), 64'h4); check("sat_err", 64'(proto_error), 64'h1);

    // unexpected packet at cnt 0, then issue coincident with accept at cnt 2
    reset = 1;
    step(); reset = 0; bus_can_receive = 1; bus_pc = 32'h0000_4444; bus_exec_mask = 4'b1000;
    step(); bus_can_receive = 0;
    neg();
    check("ue_valid", 64'(redirect_valid), 64'h1);
    check("ue_pc",    64'(redirect_pc),    64'h4444);
    check("ue_err",   64'(proto_error),    64'h1);
    redirect_ready = 1;
    step(); redirect_ready = 0; branch_issued = 1;
    step();
    step(); branch_issued = 0; bus_can_receive = 1; bus_pc = 32'h0000_5550; bus_exec_mask = 4'b0101;
    step(); bus_can_receive = 0; redirect_ready = 1; branch_issued = 1;
    step(); redirect_ready = 0; branch_issued = 0;
    neg(); check("co_cnt", 64'(outstanding_cnt), 64'h2); check("co_pkts", 64'(pkt_count), 64'h2);

    // reset while offering drops the packet
    bus_can_receive = 1; bus_pc = 32'h0000_6660;
    step(); bus_can_receive = 0;
    neg(); check("ro_valid1", 64'(redirect_valid), 64'h1);
    reset = 1;
    step(); reset = 0;
    neg();
    check("ro_valid0", 64'(redirect_valid), 64'h0);
    check("ro_pc",     64'(redirect_pc),    64'h0);
    check("ro_pkts",   64'(pkt_count),      64'h0);

    fork
      wait (wrap_done);
      repeat (500) @(posedge clk);
    join_any
    disable fork;
    check("wrap_reached", 64'(nrecv >= 64), 64'h1);
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
